ula_shifter_seq: RTL and testbench



---
 rtl/ula_shifter_seq_pkg.sv | 19 +
 rtl/ula_shift_stage.sv | 30 +++
 rtl/ula_shifter_seq.sv | 108 ++++++++++
 tb/tb_ula_shifter_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ula_shifter_seq_pkg.sv
// Shared ULA definitions: datapath defaults, shift-mode codes and shifter FSM states.
// Rotate support is selected by the ULA_SHIFT_ROT_EN macro in the shifter files.
package ula_shifter_seq_pkg;

   localparam int unsigned ULA_BITS = 8;
   localparam int unsigned ULA_OP_W = 2;

   localparam logic [ULA_OP_W-1:0] SHIFT_SLL = 2'b00;
   localparam logic [ULA_OP_W-1:0] SHIFT_SRL = 2'b01;
   localparam logic [ULA_OP_W-1:0] SHIFT_SRA = 2'b10;
   localparam logic [ULA_OP_W-1:0] SHIFT_ROR = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } shift_state_e;

endpackage

// File: rtl/ula_shift_stage.sv
// One barrel-shifter stage: shifts/rotates by the fixed distance DIST when enabled.
// Rotate is only built when ULA_SHIFT_ROT_EN is defined; otherwise mode 2'b11 passes data through.
module ula_shift_stage
   import ula_shifter_seq_pkg::*;
#(
   parameter int unsigned BITS = 8,
   parameter int unsigned DIST = 1
) (
   input  logic [BITS-1:0]     data_i,
   input  logic [ULA_OP_W-1:0] mode_i,
   input  logic                en_i,
   output logic [BITS-1:0]     data_o
);

   always_comb begin
      data_o = data_i;
      if (en_i) begin
         case (mode_i)
            SHIFT_SLL: data_o = data_i << DIST;
            SHIFT_SRL: data_o = data_i >> DIST;
            SHIFT_SRA: data_o = BITS'($signed(data_i) >>> DIST);
`ifdef ULA_SHIFT_ROT_EN
            SHIFT_ROR: data_o = (data_i >> DIST) | (data_i << (BITS - DIST));
`endif
            default:   data_o = data_i;
         endcase
      end
   end

endmodule

// File: rtl/ula_shifter_seq.sv
// Multi-cycle barrel shifter resolving one log2 stage per clock, start/busy/done handshake.
// Define ULA_SHIFT_ROT_EN to enable rotate-right on mode 2'b11 (otherwise an identity op).
module ula_shifter_seq
   import ula_shifter_seq_pkg::*;
#(
   parameter int unsigned BITS = ULA_BITS
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                start_in,
   input  logic [ULA_OP_W-1:0] mode_in,
   input  logic [BITS-1:0]     a_in,
   input  logic [BITS-1:0]     b_in,
   output logic [BITS-1:0]     result_out,
   output logic                busy_out,
   output logic                done_out
);

   localparam int unsigned STAGES = $clog2(BITS);
   localparam int unsigned KW     = (STAGES > 1) ? $clog2(STAGES) : 1;

   shift_state_e        state_q;
   logic [BITS-1:0]     work_q;
   logic [ULA_OP_W-1:0] mode_q;
   logic [STAGES-1:0]   amt_q;
   logic [KW-1:0]       k_q;

   logic [BITS-1:0] stage_out [STAGES];
   logic [BITS-1:0] step_val;
   logic [BITS-1:0] load_val;
   logic            sat;
   logic            last_stage;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      ula_shift_stage #(
         .BITS (BITS),
         .DIST (1 << s)
      ) u_stage (
         .data_i (work_q),
         .mode_i (mode_q),
         .en_i   (amt_q[s]),
         .data_o (stage_out[s])
      );
   end

   always_comb begin
      step_val = work_q;
      for (int s = 0; s < STAGES; s++) begin
         if (k_q == KW'(s)) step_val = stage_out[s];
      end
      last_stage = (k_q == KW'(STAGES - 1));
   end

   // Amounts >= BITS saturate at launch; the stages still run so latency stays fixed.
   always_comb begin
      sat      = |(b_in >> STAGES);
      load_val = a_in;
      if (sat) begin
         case (mode_in)
            SHIFT_SLL, SHIFT_SRL: load_val = '0;
            SHIFT_SRA:            load_val = {BITS{a_in[BITS-1]}};
            default:              load_val = a_in;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= StIdle;
         work_q     <= '0;
         mode_q     <= SHIFT_SLL;
         amt_q      <= '0;
         k_q        <= '0;
         result_out <= '0;
         busy_out   <= 1'b0;
         done_out   <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               done_out <= 1'b0;
               if (start_in) begin
                  work_q   <= load_val;
                  mode_q   <= mode_in;
                  amt_q    <= b_in[STAGES-1:0];
                  k_q      <= '0;
                  busy_out <= 1'b1;
                  state_q  <= StShift;
               end else begin
                  state_q <= StIdle;
               end
            end
            StShift: begin
               work_q <= step_val;
               k_q    <= k_q + 1'b1;
               if (last_stage) begin
                  result_out <= step_val;
                  done_out   <= 1'b1;
                  busy_out   <= 1'b0;
                  k_q        <= '0;
                  state_q    <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_shifter_seq.sv
// Self-checking bench for ula_shifter_seq (BITS=8): directed literals plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_ula_shifter_seq;

   localparam int unsigned BITS   = 8;
   localparam int          STAGES = 3;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode  = 2'b00;
   logic [7:0] a     = 8'h00;
   logic [7:0] b     = 8'h00;
   logic [7:0] result;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   logic [7:0] m_res  = 8'h00;
   logic [7:0] m_pend = 8'h00;
   int         m_cnt  = 0;

   always #5 clk = ~clk;

   ula_shifter_seq #(
      .BITS (BITS)
   ) dut (
      .clk_in     (clk),
      .rst_in     (rst),
      .start_in   (start),
      .mode_in    (mode),
      .a_in       (a),
      .b_in       (b),
      .result_out (result),
      .busy_out   (busy),
      .done_out   (done)
   );

   function automatic logic [7:0] ref_shift(input logic [7:0] av, input logic [7:0] bv,
                                            input logic [1:0] m);
      int ia = int'(av);
      int ib = int'(bv);
      int sa;
      int r;
      case (m)
         2'b00: return (ib >= 8) ? 8'h00 : 8'((ia << ib) & 255);
         2'b01: return av >> bv;
         2'b10: begin
            sa = av[7] ? ia - 256 : ia;
            if (ib >= 8) return av[7] ? 8'hFF : 8'h00;
            return 8'(sa >>> ib);
         end
         default: begin
`ifdef ULA_SHIFT_ROT_EN
            r = ib % 8;
            return 8'(((ia >> r) | (ia << (8 - r))) & 255);
`else
            r = 0;
            return av;
`endif
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference: an accepted op completes STAGES edges after launch.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_res  = 8'h00;
         m_cnt  = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_res  = m_pend;
               m_done = 1'b1;
               m_busy = 1'b0;
            end
         end else if (start) begin
            m_pend = ref_shift(a, b, mode);
            m_cnt  = STAGES;
            m_busy = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_busy", 32'(busy), 32'(m_busy));
         chk("cyc_done", 32'(done), 32'(m_done));
         chk("cyc_result", 32'(result), 32'(m_res));
      end
   end

   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] m,
                         input logic [7:0] exp, input string name);
      int busy_n = 0;
      bit seen   = 1'b0;
      a     = av;
      b     = bv;
      mode  = m;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done) seen = 1'b1;
      end
      chk({name, "_done_seen"}, 32'(seen), 32'd1);
      chk({name, "_result"}, 32'(result), 32'(exp));
      chk({name, "_busy_cycles"}, 32'(busy_n), 32'd3);
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cmp_en = 1'b1;
      step();
      step();
      rst = 1'b0;
      repeat (5) step();
      @(negedge clk);
      chk("reset_result", 32'(result), 32'h00);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      step();

      chk("model_srl", 32'(ref_shift(8'hB4, 8'd3, 2'b01)), 32'h16);
      chk("model_sra", 32'(ref_shift(8'hB4, 8'd2, 2'b10)), 32'hED);
      chk("model_sll", 32'(ref_shift(8'h81, 8'd1, 2'b00)), 32'h02);

      run_op(8'hB4, 8'd3, 2'b01, 8'h16, "srl_b4_3");
      run_op(8'hB4, 8'd2, 2'b10, 8'hED, "sra_b4_2");
      run_op(8'hB4, 8'd200, 2'b10, 8'hFF, "sra_sat");
      run_op(8'h81, 8'd1, 2'b00, 8'h02, "sll_81_1");
      run_op(8'h81, 8'd8, 2'b00, 8'h00, "sll_sat");
`ifdef ULA_SHIFT_ROT_EN
      run_op(8'h81, 8'd9, 2'b11, 8'hC0, "ror_81_9");
`else
      run_op(8'h81, 8'd9, 2'b11, 8'h81, "illegal_11");
`endif
      run_op(8'h7F, 8'd255, 2'b01, 8'h00, "srl_sat");

      // Start held while busy must not disturb the op in flight.
      a = 8'h81; b = 8'd1; mode = 2'b00; start = 1'b1;
      step();
      a = 8'hFF; b = 8'd3; mode = 2'b01;
      repeat (3) step();
      start = 1'b0;
      @(negedge clk);
      chk("ignore_done", 32'(done), 32'd1);
      chk("ignore_result", 32'(result), 32'h02);
      step();
      repeat (2) step();

      // Back-to-back launch from the DONE cycle.
      a = 8'hB4; b = 8'd3; mode = 2'b01; start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      a = 8'h81; b = 8'd1; mode = 2'b00;
      step();
      start = 1'b1;
      @(negedge clk);
      chk("b2b_first_done", 32'(done), 32'd1);
      chk("b2b_first_result", 32'(result), 32'h16);
      step();
      start = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("b2b_second_done", 32'(done), 32'd1);
      chk("b2b_second_result", 32'(result), 32'h02);
      step();
      repeat (2) step();

      // Reset mid-SHIFT discards the op.
      a = 8'hFF; b = 8'd1; mode = 2'b01; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", 32'(result), 32'h00);
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst_no_done", 32'(done), 32'd0);
         step();
      end

      for (int i = 0; i < 3000; i++) begin
         start = 1'($urandom % 2);
         mode  = 2'($urandom % 4);
         a     = 8'($urandom);
         b     = ($urandom % 2 == 0) ? 8'($urandom % 8) : 8'($urandom);
         step();
      end
      start = 1'b0;
      repeat (6) step();

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
